// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: M:SS BCD countdown with internal one-second prescaler, pause/resume and clear.
module bcd_countdown_timer #(
  parameter int TICKS_PER_SEC = 100,
  parameter int PRESC_W = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_min,
  input  logic [3:0] load_sec_tens,
  input  logic [3:0] load_sec_ones,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] min,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done,
  output logic       zero
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
  state_t state, state_n;
  logic [PRESC_W-1:0] presc, presc_n;
  logic [3:0] min_n, tens_n, ones_n, dec_min, dec_tens, dec_ones;
  logic done_n, tick, dec_zero;
  function automatic logic [3:0] sat(input logic [3:0] v, input logic [3:0] hi);
    return v > hi ? hi : v;
  endfunction
  assign zero = min == 4'd0 && sec_tens == 4'd0 && sec_ones == 4'd0;
  assign running = state == RUN;
  assign tick = state == RUN && presc == PRESC_W'(TICKS_PER_SEC - 1);
  assign dec_ones = sec_ones != 4'd0 ? sec_ones - 4'd1 : 4'd9;
  assign dec_tens = sec_ones != 4'd0 ? sec_tens : sec_tens != 4'd0 ? sec_tens - 4'd1 : 4'd5;
  assign dec_min = (sec_ones == 4'd0 && sec_tens == 4'd0 && min != 4'd0) ? min - 4'd1 : min;
  assign dec_zero = dec_min == 4'd0 && dec_tens == 4'd0 && dec_ones == 4'd0;
  always_comb begin
    state_n = state;
    presc_n = presc;
    min_n = min;
    tens_n = sec_tens;
    ones_n = sec_ones;
    done_n = 1'b0;
    if (state == RUN) begin
      presc_n = tick ? '0 : presc + 1'b1;
      min_n = tick && !zero ? dec_min : min;
      tens_n = tick && !zero ? dec_tens : sec_tens;
      ones_n = tick && !zero ? dec_ones : sec_ones;
    end
    if (clear) begin
      state_n = IDLE;
      presc_n = '0;
      min_n = 4'd0;
      tens_n = 4'd0;
      ones_n = 4'd0;
    end else if (tick && dec_zero) begin
      state_n = DONE;
      done_n = 1'b1;
    end else if (stop) begin
      state_n = state == RUN ? PAUSED : state;
    end else if (start) begin
      if (!zero && state != RUN) begin
        state_n = RUN;
        presc_n = state == PAUSED ? presc : '0;
      end
    end else if (load && state != RUN) begin
      min_n = sat(load_min, 4'd9);
      tens_n = sat(load_sec_tens, 4'd5);
      ones_n = sat(load_sec_ones, 4'd9);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      presc <= '0;
      min <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      presc <= presc_n;
      min <= min_n;
      sec_tens <= tens_n;
      sec_ones <= ones_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: scoreboard bench; model counts whole seconds and derives digits arithmetically.
module tb_bcd_countdown_timer;
  localparam int T = 4;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [3:0] load_min = '0, load_sec_tens = '0, load_sec_ones = '0;
  logic [3:0] min, sec_tens, sec_ones;
  logic running, done, zero;
  int checks = 0, errors = 0;
  int m_secs = 0, m_mode = 0, m_ph = 0;
  bit m_done = 1'b0;
  logic [14:0] exp_q[$];
  always #5 clk = ~clk;
  bcd_countdown_timer #(.TICKS_PER_SEC(T), .PRESC_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_min(load_min),
    .load_sec_tens(load_sec_tens), .load_sec_ones(load_sec_ones),
    .start(start), .stop(stop), .clear(clear), .min(min), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .running(running), .done(done), .zero(zero)
  );
  function automatic logic [14:0] dut_out();
    return {min, sec_tens, sec_ones, running, done, zero};
  endfunction
  function automatic logic [14:0] model_out();
    return {4'(m_secs / 60), 4'((m_secs % 60) / 10), 4'(m_secs % 10), m_mode == 1, m_done, m_secs == 0};
  endfunction
  function automatic int clip(int v, int hi);
    return v > hi ? hi : v;
  endfunction
  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d:%0d%0d run=%b done=%b zero=%b, expected %0d:%0d%0d run=%b done=%b zero=%b",
               name, act[14:11], act[10:7], act[6:3], act[2], act[1], act[0],
               exp[14:11], exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask
  // modes: 0 idle, 1 run, 2 paused, 3 done
  task automatic model_step(input bit ld, input int lm, input int lt, input int lo,
                            input bit st, input bit sp, input bit cl);
    bit was_zero, tk;
    was_zero = m_secs == 0;
    tk = 1'b0;
    m_done = 1'b0;
    if (m_mode == 1) begin
      tk = m_ph == T - 1;
      m_ph = tk ? 0 : m_ph + 1;
      if (tk && m_secs > 0) m_secs--;
    end
    if (cl) begin
      m_secs = 0; m_ph = 0; m_mode = 0;
    end else if (tk && m_secs == 0) begin
      m_mode = 3; m_done = 1'b1;
    end else if (sp) begin
      if (m_mode == 1) m_mode = 2;
    end else if (st) begin
      if (!was_zero && m_mode != 1) begin
        if (m_mode != 2) m_ph = 0;
        m_mode = 1;
      end
    end else if (ld && m_mode != 1) begin
      m_secs = clip(lm, 9) * 60 + clip(lt, 5) * 10 + clip(lo, 9);
    end
  endtask
  task automatic drive(input bit ld, input int lm, input int lt, input int lo,
                       input bit st, input bit sp, input bit cl);
    load = ld; load_min = 4'(lm); load_sec_tens = 4'(lt); load_sec_ones = 4'(lo);
    start = st; stop = sp; clear = cl;
    model_step(ld, lm, lt, lo, st, sp, cl);
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_load(input int m, input int t, input int o);
    drive(1, m, t, o, 0, 0, 0);
  endtask
  task automatic do_start();
    drive(0, 0, 0, 0, 1, 0, 0);
  endtask
  task automatic do_clear();
    drive(0, 0, 0, 0, 0, 0, 1);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) check("scoreboard", dut_out(), exp_q.pop_front());
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end
  initial begin
    int r;
    #12;
    check("reset_state", dut_out(), {12'h000, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    do_load(1, 0, 5);
    do_start();
    idle(24);
    check("t1_0_59", dut_out(), {4'd0, 4'd5, 4'd9, 1'b1, 1'b0, 1'b0});
    do_clear();
    do_load(0, 0, 2);
    do_start();
    idle(8);
    check("t2_done_pulse", dut_out(), {12'h000, 1'b0, 1'b1, 1'b1});
    idle(1);
    check("t2_done_cleared", dut_out(), {12'h000, 1'b0, 1'b0, 1'b1});
    do_start();
    check("t2_start_at_zero", dut_out(), {12'h000, 1'b0, 1'b0, 1'b1});
    do_load(0, 1, 0);
    do_start();
    idle(5);
    drive(0, 0, 0, 0, 0, 1, 0);
    check("t3_paused", dut_out(), {4'd0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0});
    idle(20);
    check("t3_hold", dut_out(), {4'd0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0});
    do_start();
    idle(1);
    check("t3_resume_1", dut_out(), {4'd0, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0});
    idle(1);
    check("t3_resume_2", dut_out(), {4'd0, 4'd0, 4'd8, 1'b1, 1'b0, 1'b0});
    do_clear();
    do_load(12, 7, 15);
    check("t4_saturate", dut_out(), {4'd9, 4'd5, 4'd9, 1'b0, 1'b0, 1'b0});
    do_start();
    idle(2);
    do_load(1, 2, 3);
    check("t5_load_in_run", dut_out(), {4'd9, 4'd5, 4'd9, 1'b1, 1'b0, 1'b0});
    do_clear();
    check("t5_clear_on_tick", dut_out(), {12'h000, 1'b0, 1'b0, 1'b1});
    do_load(3, 4, 2);
    do_start();
    idle(4);
    check("t6_3_41", dut_out(), {4'd3, 4'd4, 4'd1, 1'b1, 1'b0, 1'b0});
    idle(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", dut_out(), {12'h000, 1'b0, 1'b0, 1'b1});
    m_secs = 0; m_mode = 0; m_ph = 0; m_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_start();
    check("t6_start_zero", dut_out(), {12'h000, 1'b0, 1'b0, 1'b1});
    do_load(0, 3, 0);
    do_start();
    idle(2);
    drive(0, 0, 0, 0, 1, 1, 0);
    check("stop_start_run", dut_out(), {4'd0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0});
    drive(0, 0, 0, 0, 1, 1, 0);
    check("stop_start_paused", dut_out(), {4'd0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0});
    drive(1, 5, 5, 5, 1, 0, 0);
    check("load_start", dut_out(), {4'd0, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0});
    do_clear();
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) do_clear();
      else if (r < 10)
        do_load($urandom_range(0, 3) == 0 ? int'($urandom_range(0, 15)) : 0,
                $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 15)) : 0,
                int'($urandom_range(0, 15)));
      else if (r < 18) do_start();
      else if (r < 22) drive(0, 0, 0, 0, 0, 1, 0);
      else idle(1);
    end
    idle(2);
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Countdown core for the M:SS timer display. Produces three BCD digits: min (0-9), sec_tens (0-5) and sec_ones (0-9).
- These digits drive the BCD-to-7-segment decoder stage directly downstream.
- Loads a start time, counts down once per second using a tick from an internal prescaler, and supports pause, resume and clear.
- Flags completion at 0:00.

Parameters:
- TICKS_PER_SEC, default 100: clk cycles per one-second decrement. Legal range is 2 to 2^24. Synthesis overrides it with the board clock rate.
- PRESC_W, default 24: prescaler counter width. Must hold TICKS_PER_SEC-1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  single-cycle pulse; captures the load_* digits.
- load_min  in  4  BCD minutes to load.
- load_sec_tens  in  4  BCD tens-of-seconds to load.
- load_sec_ones  in  4  BCD seconds to load.
- start  in  1  pulse; begins or resumes the countdown.
- stop  in  1  pulse; pauses the countdown.
- clear  in  1  pulse; returns the block to 0:00 in IDLE.
- min  out  4  current minutes digit, registered.
- sec_tens  out  4  current tens-of-seconds digit, registered.
- sec_ones  out  4  current seconds digit, registered.
- running  out  1  high while in state RUN.
- done  out  1  one-cycle pulse on reaching 0:00 from RUN.
- zero  out  1  high whenever all three digits are 0.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; min=sec_tens=sec_ones=0; prescaler=0.
  - running=0, done=0, zero=1.
- States and transitions:
  - IDLE: start with a nonzero count goes to RUN.
  - RUN: stop goes to PAUSED. Reaching 0:00 goes to DONE.
  - PAUSED: start goes to RUN.
  - DONE: start with a nonzero count goes to RUN. load stays in DONE and updates the digits.
  - Any state: clear goes to IDLE.
- Input priority in a single cycle: clear > stop > start > load.
  - stop and start together in RUN: stay PAUSED-bound, i.e. go to PAUSED.
  - stop and start together in PAUSED: stay PAUSED.
- Load:
  - Accepted only in IDLE, PAUSED and DONE. Ignored in RUN.
  - Digits update on the next clock edge.
  - Out-of-range values saturate: min>9 becomes 9, sec_tens>5 becomes 5, sec_ones>9 becomes 9.
  - Load and start in the same cycle: start wins and load is dropped.
- Start:
  - Ignored when zero=1 (no transition, no done pulse).
  - From IDLE or DONE, the prescaler resets to 0.
  - From PAUSED, the prescaler keeps its held value, so a partial second is preserved.
- Prescaler:
  - Increments only in RUN.
  - Tick occurs in the cycle where prescaler==TICKS_PER_SEC-1; the prescaler then wraps to 0.
  - The first decrement lands exactly TICKS_PER_SEC cycles after the start edge.
- Decrement on tick (borrow chain):
  - sec_ones>0: sec_ones-1.
  - Else sec_ones=9 and sec_tens borrows.
  - sec_tens>0: sec_tens-1.
  - Else sec_tens=5 and min borrows.
  - min-1 only when min>0.
  - Example: 1:00 becomes 0:59.
- Terminal count:
  - The tick that makes the digits 0:00 moves the state to DONE on the same edge.
  - done=1 for exactly that one following cycle. running=0 from that edge.
  - The count never wraps below 0:00.
- Clear: digits=0, prescaler=0, state=IDLE. done is forced to 0 even if a tick coincides.
- Pause: the digits are held stable throughout PAUSED.
- Output timing: all outputs come from registers; there are no combinational paths from inputs to outputs.
  - running is decoded from the state register.
  - zero is decoded from the digit registers.
- Reset mid-count: immediate return to the reset values regardless of state.

Test Plan (TICKS_PER_SEC=4):
1. Reset, then load 1:05 and start. Digits go 1:04 after 4 cycles, then 1:03, 1:02, 1:01, 1:00, 0:59. No done pulse.
2. Load 0:02, start. After 8 cycles: 0:00, state DONE, done high for exactly 1 cycle, running=0, zero=1. A further start is ignored.
3. Load 0:10, start, stop after 6 cycles (digits read 0:09). Hold 20 cycles: digits stay 0:09. Start again: 0:08 appears 2 cycles later (preserved prescaler phase).
4. Load min=12, sec_tens=7, sec_ones=15. Digits read 9:59.
5. Assert load in RUN: ignored. Assert clear together with a tick: digits 0:00, IDLE, done=0.
6. Drop rst_n asynchronously mid-run at 3:41, between clock edges. Outputs clear immediately to 0:00, running=0. After release, a start with count zero is ignored.
